// File: rtl/tone_pkg.sv
// tone_pkg: constants shared by the tone divider and the note-index-to-code table
package tone_pkg;
  localparam int CODE_W = 11;
  localparam logic [CODE_W-1:0] REST_CODE = 11'h7FF;
  localparam logic [CODE_W-1:0] CNT_MAX = 11'h7FF;
endpackage

// File: rtl/tone_divider.sv
// tone_divider: reloadable up-counter driving a glitch-free square-wave speaker tone
module tone_divider #(
  parameter int CODE_W = tone_pkg::CODE_W,
  parameter logic [CODE_W-1:0] REST_CODE = tone_pkg::REST_CODE
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE,
  input  logic [CODE_W-1:0] F_CODE,
  input  logic              LOAD,
  output logic              SPK_OUT,
  output logic              TICK,
  output logic [CODE_W-1:0] CODE_Q
);
  logic [CODE_W-1:0] cnt, pend, next_code;
  logic pend_v, ovf;
  // RST_N gates the overflow so TICK stays low while reset holds cnt at its maximum
  always_comb begin
    ovf = RST_N && CE && cnt == CODE_W'(tone_pkg::CNT_MAX);
    next_code = LOAD ? F_CODE : pend_v ? pend : CODE_Q;
  end
  assign TICK = ovf;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= CODE_W'(tone_pkg::CNT_MAX);
      CODE_Q <= REST_CODE;
      pend <= REST_CODE;
      pend_v <= 1'b0;
      SPK_OUT <= 1'b0;
    end else begin
      if (LOAD) begin
        pend <= F_CODE;
        pend_v <= 1'b1;
      end
      // a LOAD coinciding with overflow is applied directly, so nothing stays pending
      if (ovf) begin
        cnt <= next_code;
        CODE_Q <= next_code;
        pend_v <= 1'b0;
        SPK_OUT <= next_code == REST_CODE ? 1'b0 : ~SPK_OUT;
      end else if (CE) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
